// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: delays the pixel stream by LEAD clocks so the video preamble
// and leading guard band can be placed in front of every active line.
module hdmi_period_scheduler #(
   parameter bit          HDMI_MODE = 1'b1,
   parameter int unsigned PRE_LEN   = 8,
   parameter int unsigned GB_LEN    = 2
) (
   input  logic        video_clk_pix,
   input  logic        rst_n,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [23:0] rgb_in,
   output logic [7:0]  vd0,
   output logic [7:0]  vd1,
   output logic [7:0]  vd2,
   output logic [1:0]  cd0,
   output logic [1:0]  cd1,
   output logic [1:0]  cd2,
   output logic        vde,
   output logic        gb_en,
   output logic [29:0] gb_sym,
   output logic        short_blank
);

   localparam int unsigned LEAD   = PRE_LEN + GB_LEN;
   localparam int unsigned CNT_W  = 4;
   localparam logic [29:0] GB_SYM = {10'b1011001100, 10'b0100110011, 10'b1011001100};

   typedef struct packed {
      logic        de;
      logic        vs;
      logic        hs;
      logic [23:0] rgb;
   } pix_t;

   typedef enum logic [1:0] {CTRL, PRE, GB, VID} state_e;

   pix_t             pipe_q [LEAD];
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sb_q, sb_d;
   logic             vde_q, vde_d;
   logic             gb_en_q, gb_en_d;
   logic [23:0]      vd_q, vd_d;
   logic [5:0]       cd_q, cd_d;
   logic [29:0]      gb_sym_q, gb_sym_d;
   logic             de_d;
   logic             de_rise_c;
   pix_t             pix_d;

   assign pix_d     = pipe_q[LEAD-1];
   assign de_d      = pix_d.de;
   // Stage 0 holds last clock's de_in, so it doubles as the edge detector history.
   assign de_rise_c = de_in & ~pipe_q[0].de;

   always_ff @(posedge video_clk_pix) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LEAD; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{de: de_in, vs: vsync_in, hs: hsync_in, rgb: rgb_in};
         for (int unsigned i = 1; i < LEAD; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   always_ff @(posedge video_clk_pix) begin
      if (!rst_n) begin
         state_q  <= CTRL;
         cnt_q    <= '0;
         sb_q     <= 1'b0;
         vde_q    <= 1'b0;
         gb_en_q  <= 1'b0;
         vd_q     <= '0;
         cd_q     <= '0;
         gb_sym_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sb_q     <= sb_d;
         vde_q    <= vde_d;
         gb_en_q  <= gb_en_d;
         vd_q     <= vd_d;
         cd_q     <= cd_d;
         gb_sym_q <= gb_sym_d;
      end
   end

   // Next state; a delayed-de rise in CTRL wins over starting a new preamble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sb_d    = sb_q;
      if (HDMI_MODE && de_rise_c && !(state_q == CTRL && !de_d)) sb_d = 1'b1;
      case (state_q)
         CTRL: begin
            if (de_d) begin
               state_d = VID;
            end else if (HDMI_MODE && de_rise_c) begin
               state_d = PRE;
               cnt_d   = CNT_W'(PRE_LEN - 1);
            end
         end
         PRE: begin
            if (cnt_q == '0) begin
               state_d = GB;
               cnt_d   = CNT_W'(GB_LEN - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GB: begin
            if (cnt_q == '0) state_d = VID;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         VID: begin
            if (!de_d) state_d = CTRL;
         end
         default: state_d = CTRL;
      endcase
   end

   // Outputs are registered from the next state so they line up with the delayed pixels.
   always_comb begin
      vde_d    = (state_d == VID);
      gb_en_d  = (state_d == GB);
      vd_d     = vde_d   ? pix_d.rgb : '0;
      gb_sym_d = gb_en_d ? GB_SYM    : '0;
      cd_d     = cd_q;
      if (state_d != VID) begin
         cd_d[1:0] = {pix_d.vs, pix_d.hs};
         cd_d[3:2] = (state_d == PRE) ? 2'b01 : 2'b00;
         cd_d[5:4] = (state_d == PRE) ? 2'b01 : 2'b00;
      end
   end

   assign vd0         = vd_q[7:0];
   assign vd1         = vd_q[15:8];
   assign vd2         = vd_q[23:16];
   assign cd0         = cd_q[1:0];
   assign cd1         = cd_q[3:2];
   assign cd2         = cd_q[5:4];
   assign vde         = vde_q;
   assign gb_en       = gb_en_q;
   assign gb_sym      = gb_sym_q;
   assign short_blank = sb_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Randomized bench for hdmi_period_scheduler: HDMI and DVI instances share stimulus and
// are checked every clock against a line-level model built from input history.
module tb_hdmi_period_scheduler;

   localparam int unsigned PRE_LEN = 8;
   localparam int unsigned GB_LEN  = 2;
   localparam int unsigned LEAD    = PRE_LEN + GB_LEN;
   localparam int          MAXC    = 8192;
   localparam logic [29:0] GBS     = {10'b1011001100, 10'b0100110011, 10'b1011001100};

   logic        clk = 1'b0;
   logic        rst_n, de_in, hsync_in, vsync_in;
   logic [23:0] rgb_in;

   logic [7:0]  h_vd0, h_vd1, h_vd2, d_vd0, d_vd1, d_vd2;
   logic [1:0]  h_cd0, h_cd1, h_cd2, d_cd0, d_cd1, d_cd2;
   logic        h_vde, h_gb_en, h_sb, d_vde, d_gb_en, d_sb;
   logic [29:0] h_gb_sym, d_gb_sym;

   always #5 clk = ~clk;

   hdmi_period_scheduler #(.HDMI_MODE(1'b1), .PRE_LEN(PRE_LEN), .GB_LEN(GB_LEN)) dut_h (
      .video_clk_pix(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .rgb_in(rgb_in),
      .vd0(h_vd0), .vd1(h_vd1), .vd2(h_vd2), .cd0(h_cd0), .cd1(h_cd1), .cd2(h_cd2),
      .vde(h_vde), .gb_en(h_gb_en), .gb_sym(h_gb_sym), .short_blank(h_sb));

   hdmi_period_scheduler #(.HDMI_MODE(1'b0), .PRE_LEN(PRE_LEN), .GB_LEN(GB_LEN)) dut_d (
      .video_clk_pix(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in), .rgb_in(rgb_in),
      .vd0(d_vd0), .vd1(d_vd1), .vd2(d_vd2), .cd0(d_cd0), .cd1(d_cd1), .cd2(d_cd2),
      .vde(d_vde), .gb_en(d_gb_en), .gb_sym(d_gb_sym), .short_blank(d_sb));

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;

   // Per-cycle input history; h_rst marks cycles with rst_n low.
   bit          h_rst [MAXC];
   bit          h_de  [MAXC];
   bit          h_hs  [MAXC];
   bit          h_vs  [MAXC];
   logic [23:0] h_rgb [MAXC];

   // Model state: last reset cycle, cycle of the last preamble-starting rise, sticky flag.
   int          last_r    = 0;
   int          pre_n     = -100;
   bit          sb        = 1'b0;
   bit          busy_prev = 1'b0;
   logic [5:0]  cdl       = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic evaluate();
      bit          ed, ehs, evs, rise, prev_de, acc, pre, gb;
      logic [23:0] ergb;
      int          n;
      ed = 1'b0; ehs = 1'b0; evs = 1'b0; ergb = '0; pre = 1'b0; gb = 1'b0;
      if (h_rst[cyc-1]) begin
         last_r    = cyc - 1;
         pre_n     = -100;
         sb        = 1'b0;
         cdl       = '0;
         busy_prev = 1'b0;
      end else begin
         if (cyc - int'(LEAD) - 1 > last_r) begin
            ed   = h_de[cyc-LEAD-1];
            ehs  = h_hs[cyc-LEAD-1];
            evs  = h_vs[cyc-LEAD-1];
            ergb = h_rgb[cyc-LEAD-1];
         end
         n       = cyc - 1;
         prev_de = (n - 1 == last_r) ? 1'b0 : h_de[n-1];
         rise    = h_de[n] && !prev_de;
         // A rise starts a preamble only if the scheduler is idle and no line is due out.
         acc     = rise && !busy_prev && !ed;
         if (acc) pre_n = n;
         if (rise && !acc) sb = 1'b1;
         pre = (cyc >= pre_n + 1) && (cyc <= pre_n + int'(PRE_LEN));
         gb  = (cyc > pre_n + int'(PRE_LEN)) && (cyc <= pre_n + int'(LEAD));
         if (!ed) cdl = {pre ? 2'b01 : 2'b00, pre ? 2'b01 : 2'b00, evs, ehs};
         busy_prev = pre || gb || ed;
      end
      check("h_vde",    32'(h_vde),                 32'(ed));
      check("h_gb_en",  32'(h_gb_en),               32'(gb));
      check("h_gb_sym", 32'(h_gb_sym),              32'(gb ? GBS : 30'd0));
      check("h_vd",     32'({h_vd2, h_vd1, h_vd0}), 32'(ed ? ergb : 24'd0));
      check("h_cd",     32'({h_cd2, h_cd1, h_cd0}), 32'(cdl));
      check("h_sblank", 32'(h_sb),                  32'(sb));
      check("d_vde",    32'(d_vde),                 32'(ed));
      check("d_gb_en",  32'({d_gb_en, d_gb_sym}),   32'd0);
      check("d_vd",     32'({d_vd2, d_vd1, d_vd0}), 32'(ed ? ergb : 24'd0));
      check("d_cd",     32'({d_cd2, d_cd1, d_cd0}), 32'({4'b0000, cdl[1:0]}));
   endtask

   task automatic step(input bit rst, input bit de, input logic [23:0] rgb);
      if (cyc >= MAXC - 2) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 2);
         $fatal(1, "cycle budget exhausted");
      end
      rst_n    = !rst;
      de_in    = de;
      rgb_in   = rgb;
      hsync_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) vsync_in = ~vsync_in;
      h_rst[cyc] = rst;
      h_de[cyc]  = de;
      h_hs[cyc]  = hsync_in;
      h_vs[cyc]  = vsync_in;
      h_rgb[cyc] = rgb;
      @(posedge clk);
      #1;
      cyc++;
      evaluate();
   endtask

   task automatic gap(input int len);
      for (int i = 0; i < len; i++) step(1'b0, 1'b0, 24'($urandom));
   endtask

   task automatic line(input int len, input bit fixed, input logic [23:0] rgb);
      for (int i = 0; i < len; i++) step(1'b0, 1'b1, fixed ? rgb : 24'($urandom));
   endtask

   initial begin
      vsync_in = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'd0);
      gap(100);
      line(16, 1'b1, 24'h112233);
      gap(5);
      line(16, 1'b1, 24'h445566);
      gap(40);
      line(1, 1'b1, 24'hA5A5A5);
      gap(30);
      line(3, 1'b0, 24'd0);
      gap(6);
      step(1'b1, 1'b0, 24'd0);
      gap(30);
      line(16, 1'b0, 24'd0);
      gap(11);
      line(14, 1'b0, 24'd0);
      gap(10);
      line(12, 1'b0, 24'd0);
      gap(30);
      for (int k = 0; k < 60; k++) begin
         int len;
         len = $urandom_range(1, 20);
         line(len, 1'b0, 24'd0);
         if (len >= 12 && $urandom_range(0, 1) == 1) gap($urandom_range(1, 10));
         else                                       gap($urandom_range(11, 40));
      end
      gap(20);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
